px_stream_tx: RTL and testbench
===============================

Name: px_stream_tx

Overview:
- Programmable pixel-stream transmitter; the source end of the hstr/href/hend/vstr/vend pixel interface that the ISP blocks (tone_mapping and similar) consume.
- Generates frame and line timing plus synthetic pixel data, so downstream blocks can be driven in system builds, not only by the behavioural sensor model.
- Output stream is timing-identical to the bench convention:
  - hstr coincides with the first href cycle.
  - hend is asserted on the cycle after the last href cycle.

Parameters:
DW, 10, pixel data width
CW, 16, width of size/counter registers
FW, 8, width of frame-count register

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_en  in  1  start/continue enable, level-sensitive
r_hwin_sz  in  CW  active pixels per line
r_vwin_sz  in  CW  active lines per frame
r_hblk_sz  in  CW  horizontal blank cycles (0 treated as 1)
r_vblk_sz  in  CW  vertical blank cycles after vend (0 allowed)
r_frm_num  in  FW  frames to send per start; 0 = continuous
r_pat_sel  in  2  0 x-ramp, 1 y-ramp, 2 x+y, 3 constant
r_pat_const  in  DW  constant pattern value
o_vstr  out  1  frame start pulse
o_vend  out  1  frame end pulse
o_hstr  out  1  line start pulse
o_href  out  1  pixel valid
o_hend  out  1  line end pulse
o_data  out  DW  pixel data, valid only when o_href=1, else 0
o_busy  out  1  high while not IDLE
o_frm_done  out  1  one-cycle pulse when a frame burst completes

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Reset: every output is 0 and the FSM is in IDLE on the first edge with rst=1. rst mid-frame aborts immediately with no vend and no frm_done.
- All outputs are registered. The FSM state listed below is the state whose outputs are visible in that cycle.
- FSM states: IDLE, VSTR, HBLK, LINE, VEND, VBLK.
- IDLE:
  - Exits to VSTR when i_en=1 and hwin!=0 and vwin!=0.
  - Otherwise stays in IDLE; zero sizes are never started.
  - On entry to VSTR, all r_* inputs are shadowed. Register changes mid-frame take effect at the next VSTR.
- VSTR (1 cycle): o_vstr=1; line_cnt=0. Goes to HBLK.
- HBLK (hblk_eff = max(r_hblk_sz,1) cycles):
  - o_hend=1 in the first HBLK cycle only when the previous state was LINE.
  - At expiry: goes to VEND if line_cnt==vwin, else to LINE.
- LINE (hwin cycles):
  - o_href=1 throughout; o_hstr=1 in the first cycle; x_cnt runs 0..hwin-1.
  - After the last cycle: line_cnt+1, goes to HBLK.
- VEND (1 cycle): o_vend=1, asserted the cycle after the final hend cycle's HBLK expires. Goes to VBLK, or directly to the next decision if vblk=0.
- VBLK (r_vblk_sz cycles), then the decision:
  - If (r_frm_num==0 or frm_cnt<r_frm_num) and i_en=1: go to VSTR.
  - Else: go to IDLE with a o_frm_done pulse on the transition cycle.
- i_en deasserted mid-frame: the current frame completes normally, then IDLE plus o_frm_done.
- Frame period = 2 + vblk + hblk_eff + vwin*(hwin+hblk_eff) cycles.
- frm_cnt:
  - Cleared when starting from IDLE; increments at VEND.
  - In continuous mode it saturates at its maximum value and does not wrap.
- Data patterns, truncated to DW LSBs, no saturation:
  - 0: x_cnt
  - 1: y = line_cnt (line index, 0-based)
  - 2: x_cnt + y
  - 3: r_pat_const
- hwin=1: hstr, href and the single pixel occur in the same cycle; hend follows next cycle.
- o_busy=0 only in IDLE.

Test Plan:
- Basic frame: hwin=4, vwin=2, hblk=3, vblk=5, frm_num=1, pat=0, i_en=1 → vstr@t0, href t4–7, hstr t4, hend t8, href t11–14, hend t15, vend t18, frm_done t23, o_data 0,1,2,3 per line, period 24.
- Patterns: hwin=4, vwin=3, pat=2 → line2 data 2,3,4,5; pat=3 const=0x3FF → all pixels 0x3FF; DW=10 x-ramp with hwin=1030 → pixel 1024 = 0.
- Edges:
  - hblk=0 gives identical timing to hblk=1.
  - hwin=1 gives hstr and href on the same cycle, hend next cycle.
  - hwin=0 with i_en=1 stays IDLE, o_busy=0.
- Continuous/stop: frm_num=0, i_en=1 for 3 frames, then drop i_en mid-frame 3 → frame 3 completes with vend, frm_done, then IDLE; no 4th vstr.
- Reset mid-line: rst=1 during LINE → all outputs 0 next cycle, no vend; rst release with i_en=1 → fresh vstr with line 0 data from 0.
- Shadowing: change r_hwin_sz 4→6 mid-frame → current frame keeps 4-pixel lines, next frame uses 6.

Source files
------------

// File: rtl/px_stream_tx.sv
// Programmable pixel-stream source: frame/line timing (vstr/hstr/href/hend/vend)
// plus synthetic pattern data. All outputs are registered from next-state logic.
module px_stream_tx #(
  parameter int DW = 10,
  parameter int CW = 16,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [CW-1:0] r_hwin_sz,
  input  logic [CW-1:0] r_vwin_sz,
  input  logic [CW-1:0] r_hblk_sz,
  input  logic [CW-1:0] r_vblk_sz,
  input  logic [FW-1:0] r_frm_num,
  input  logic [1:0]    r_pat_sel,
  input  logic [DW-1:0] r_pat_const,
  output logic          o_vstr,
  output logic          o_vend,
  output logic          o_hstr,
  output logic          o_href,
  output logic          o_hend,
  output logic [DW-1:0] o_data,
  output logic          o_busy,
  output logic          o_frm_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSTR, S_HBLK, S_LINE, S_VEND, S_VBLK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] line_q, line_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          cont_q, cont_d;

  logic [CW-1:0] sh_hwin_q, sh_hwin_d;
  logic [CW-1:0] sh_vwin_q, sh_vwin_d;
  logic [CW-1:0] sh_hblk_q, sh_hblk_d;
  logic [CW-1:0] sh_vblk_q, sh_vblk_d;
  logic [FW-1:0] sh_frm_q, sh_frm_d;
  logic [1:0]    sh_pat_q, sh_pat_d;
  logic [DW-1:0] sh_const_q, sh_const_d;

  logic          vstr_q, vstr_d;
  logic          vend_q, vend_d;
  logic          hstr_q, hstr_d;
  logic          href_q, href_d;
  logic          hend_q, hend_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] hblk_eff;
  logic [CW-1:0] xy_sum;
  logic          final_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    line_d     = line_q;
    frm_d      = frm_q;
    cont_d     = cont_q;
    sh_hwin_d  = sh_hwin_q;
    sh_vwin_d  = sh_vwin_q;
    sh_hblk_d  = sh_hblk_q;
    sh_vblk_d  = sh_vblk_q;
    sh_frm_d   = sh_frm_q;
    sh_pat_d   = sh_pat_q;
    sh_const_d = sh_const_q;
    done_d     = 1'b0;
    hblk_eff   = (sh_hblk_q == '0) ? CW'(1) : sh_hblk_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_en && (r_hwin_sz != '0) && (r_vwin_sz != '0)) begin
          state_d = S_VSTR;
          frm_d   = '0;
        end
      end
      S_VSTR: begin
        state_d = S_HBLK;
        cnt_d   = '0;
      end
      S_HBLK: begin
        if (cnt_q == hblk_eff - CW'(1)) begin
          cnt_d   = '0;
          x_d     = '0;
          state_d = (line_q == sh_vwin_q) ? S_VEND : S_LINE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LINE: begin
        if (x_q == sh_hwin_q - CW'(1)) begin
          state_d = S_HBLK;
          cnt_d   = '0;
          line_d  = line_q + CW'(1);
        end else begin
          x_d = x_q + CW'(1);
        end
      end
      S_VEND: begin
        if (sh_vblk_q == '0) begin
          state_d = cont_q ? S_VSTR : S_IDLE;
        end else begin
          state_d = S_VBLK;
          cnt_d   = '0;
        end
      end
      S_VBLK: begin
        if (cnt_q == sh_vblk_q - CW'(1)) begin
          state_d = cont_q ? S_VSTR : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_HBLK) && (state_d == S_VEND) && (frm_q != '1))
      frm_d = frm_q + FW'(1);

    // Outputs are registered, so the continue/stop decision is taken one cycle
    // early, when the frame's final cycle (last VBLK, or VEND if vblk=0) is entered.
    final_next = ((state_d == S_VEND) && (sh_vblk_q == '0)) ||
                 ((state_d == S_VBLK) && (cnt_d == sh_vblk_q - CW'(1)));
    if (final_next) begin
      cont_d = ((sh_frm_q == '0) || (frm_d < sh_frm_q)) && i_en;
      done_d = !cont_d;
    end

    if (state_d == S_VSTR) begin
      line_d     = '0;
      sh_hwin_d  = r_hwin_sz;
      sh_vwin_d  = r_vwin_sz;
      sh_hblk_d  = r_hblk_sz;
      sh_vblk_d  = r_vblk_sz;
      sh_frm_d   = r_frm_num;
      sh_pat_d   = r_pat_sel;
      sh_const_d = r_pat_const;
    end

    vstr_d = (state_d == S_VSTR);
    vend_d = (state_d == S_VEND);
    href_d = (state_d == S_LINE);
    hstr_d = (state_d == S_LINE) && (x_d == '0);
    hend_d = (state_q == S_LINE) && (state_d == S_HBLK);
    busy_d = (state_d != S_IDLE);

    xy_sum = x_d + line_d;
    data_d = '0;
    if (state_d == S_LINE) begin
      unique case (sh_pat_q)
        2'd0:    data_d = DW'(x_d);
        2'd1:    data_d = DW'(line_d);
        2'd2:    data_d = DW'(xy_sum);
        default: data_d = sh_const_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      line_q     <= '0;
      frm_q      <= '0;
      cont_q     <= 1'b0;
      sh_hwin_q  <= '0;
      sh_vwin_q  <= '0;
      sh_hblk_q  <= '0;
      sh_vblk_q  <= '0;
      sh_frm_q   <= '0;
      sh_pat_q   <= '0;
      sh_const_q <= '0;
      vstr_q     <= 1'b0;
      vend_q     <= 1'b0;
      hstr_q     <= 1'b0;
      href_q     <= 1'b0;
      hend_q     <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      line_q     <= line_d;
      frm_q      <= frm_d;
      cont_q     <= cont_d;
      sh_hwin_q  <= sh_hwin_d;
      sh_vwin_q  <= sh_vwin_d;
      sh_hblk_q  <= sh_hblk_d;
      sh_vblk_q  <= sh_vblk_d;
      sh_frm_q   <= sh_frm_d;
      sh_pat_q   <= sh_pat_d;
      sh_const_q <= sh_const_d;
      vstr_q     <= vstr_d;
      vend_q     <= vend_d;
      hstr_q     <= hstr_d;
      href_q     <= href_d;
      hend_q     <= hend_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_vstr     = vstr_q;
  assign o_vend     = vend_q;
  assign o_hstr     = hstr_q;
  assign o_href     = href_q;
  assign o_hend     = hend_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;
  assign o_frm_done = done_q;

endmodule

// File: tb/tb_px_stream_tx.sv
// Self-checking bench for px_stream_tx: every output cycle of each frame is
// compared against an arithmetic frame-position model.
module tb_px_stream_tx;
  localparam int DW = 10;
  localparam int CW = 16;
  localparam int FW = 8;
  localparam int VW = 7 + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_en = 1'b0;
  logic [CW-1:0] r_hwin_sz = '0;
  logic [CW-1:0] r_vwin_sz = '0;
  logic [CW-1:0] r_hblk_sz = '0;
  logic [CW-1:0] r_vblk_sz = '0;
  logic [FW-1:0] r_frm_num = '0;
  logic [1:0]    r_pat_sel = '0;
  logic [DW-1:0] r_pat_const = '0;
  logic          o_vstr, o_vend, o_hstr, o_href, o_hend, o_busy, o_frm_done;
  logic [DW-1:0] o_data;
  logic [VW-1:0] obs_v;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  px_stream_tx #(.DW(DW), .CW(CW), .FW(FW)) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .r_hwin_sz(r_hwin_sz), .r_vwin_sz(r_vwin_sz), .r_hblk_sz(r_hblk_sz),
    .r_vblk_sz(r_vblk_sz), .r_frm_num(r_frm_num), .r_pat_sel(r_pat_sel),
    .r_pat_const(r_pat_const),
    .o_vstr(o_vstr), .o_vend(o_vend), .o_hstr(o_hstr), .o_href(o_href),
    .o_hend(o_hend), .o_data(o_data), .o_busy(o_busy), .o_frm_done(o_frm_done)
  );

  always #5 clk = ~clk;

  assign obs_v = {o_vstr, o_vend, o_hstr, o_href, o_hend, o_frm_done, o_busy, o_data};

  // Expected {vstr,vend,hstr,href,hend,done,busy,data} at cycle t of a frame.
  function automatic logic [VW-1:0] model(int unsigned t, int unsigned hw, int unsigned vw,
                                          int unsigned hb, int unsigned vb, int unsigned pat,
                                          int unsigned cst, bit last);
    int unsigned he, l, p_len, u, y, p, d;
    logic vstr, vend, hstr, href, hend, done;
    he = (hb == 0) ? 1 : hb;
    l = hw + he;
    p_len = 2 + vb + he + vw * l;
    vstr = (t == 0);
    vend = (t == 1 + he + vw * l);
    done = last && (t == p_len - 1);
    hstr = 1'b0; href = 1'b0; hend = 1'b0; d = 0;
    if (t >= 1 + he && t < 1 + he + vw * l) begin
      u = t - 1 - he;
      y = u / l;
      p = u % l;
      if (p < hw) begin
        href = 1'b1;
        hstr = (p == 0);
        case (pat)
          0: d = p;
          1: d = y;
          2: d = p + y;
          default: d = cst;
        endcase
      end
      hend = (p == hw);
    end
    d = d % (1 << DW);
    return {vstr, vend, hstr, href, hend, done, 1'b1, DW'(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [VW-1:0] exp);
    n_cmp++;
    assert (obs_v === exp) else begin
      n_err++;
      $error("FAIL %s got %h exp %h", tag, obs_v, exp);
    end
  endtask

  task automatic set_p(int unsigned hw, int unsigned vw, int unsigned hb, int unsigned vb,
                       int unsigned fn, int unsigned pat, int unsigned cst);
    r_hwin_sz = CW'(hw); r_vwin_sz = CW'(vw); r_hblk_sz = CW'(hb); r_vblk_sz = CW'(vb);
    r_frm_num = FW'(fn); r_pat_sel = 2'(pat); r_pat_const = DW'(cst);
  endtask

  task automatic wait_vstr(string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_vstr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s_vstr_timeout got %0d exp 1", tag, ok);
    end
  endtask

  // Current sample is frame cycle 0; leaves the bench at the frame's last cycle.
  task automatic run_frame(string tag, int unsigned hw, int unsigned vw, int unsigned hb,
                           int unsigned vb, int unsigned pat, int unsigned cst, bit last,
                           int unsigned new_hw);
    int unsigned he, p_len;
    he = (hb == 0) ? 1 : hb;
    p_len = 2 + vb + he + vw * (hw + he);
    for (int unsigned t = 0; t < p_len; t++) begin
      if (t > 0) tick();
      if (last && t == 1) i_en = 1'b0;
      if (new_hw != 0 && t == p_len / 2) r_hwin_sz = CW'(new_hw);
      check($sformatf("%s_t%0d", tag, t), model(t, hw, vw, hb, vb, pat, cst, last));
    end
  endtask

  task automatic check_idle(string tag, int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      check(tag, '0);
    end
  endtask

  task automatic one_frame(string tag, int unsigned hw, int unsigned vw, int unsigned hb,
                           int unsigned vb, int unsigned pat, int unsigned cst);
    set_p(hw, vw, hb, vb, 1, pat, cst);
    i_en = 1'b1;
    wait_vstr(tag);
    run_frame(tag, hw, vw, hb, vb, pat, cst, 1'b1, 0);
    check_idle({tag, "_idle"}, 3);
  endtask

  initial begin
    int unsigned hw, vw, hb, vb, fn, pat, cst;

    tick(); tick();
    check("reset", '0);
    rst = 1'b0;
    check_idle("idle_no_en", 2);

    one_frame("basic", 4, 2, 3, 5, 0, 0);
    one_frame("hblk0", 3, 2, 0, 2, 0, 0);
    one_frame("hblk1", 3, 2, 1, 2, 0, 0);
    one_frame("hwin1", 1, 3, 2, 1, 2, 0);
    one_frame("pat_xy", 4, 3, 2, 0, 2, 0);
    one_frame("pat_y", 5, 3, 1, 1, 1, 0);
    one_frame("pat_const", 4, 2, 2, 1, 3, 'h3FF);
    one_frame("wrap", 1030, 1, 1, 0, 0, 0);

    // zero window never starts
    set_p(0, 2, 2, 2, 1, 0, 0);
    i_en = 1'b1;
    check_idle("hwin0", 8);
    i_en = 1'b0;
    tick();

    // continuous mode, i_en dropped during frame 3
    set_p(3, 2, 2, 1, 0, 2, 0);
    i_en = 1'b1;
    wait_vstr("cont");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      run_frame($sformatf("cont_f%0d", k), 3, 2, 2, 1, 2, 0, k == 2, 0);
    end
    check_idle("cont_idle", 5);

    // shadowing: width change mid-frame applies to the next frame only
    set_p(4, 2, 2, 1, 2, 0, 0);
    i_en = 1'b1;
    wait_vstr("shadow");
    run_frame("shadow_f0", 4, 2, 2, 1, 0, 0, 1'b0, 6);
    tick();
    run_frame("shadow_f1", 6, 2, 2, 1, 0, 0, 1'b1, 0);
    check_idle("shadow_idle", 3);

    // reset mid-line
    set_p(5, 3, 2, 2, 1, 0, 0);
    i_en = 1'b1;
    wait_vstr("rst_mid");
    for (int i = 0; i < 4; i++) tick();
    check("rst_mid_inline", model(4, 5, 3, 2, 2, 0, 0, 1'b0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_zero", '0);
    end
    rst = 1'b0;
    wait_vstr("rst_restart");
    run_frame("rst_restart", 5, 3, 2, 2, 0, 0, 1'b1, 0);
    check_idle("rst_idle", 3);

    // randomized multi-frame bursts
    for (int r = 0; r < 5; r++) begin
      hw = $urandom_range(1, 8);
      vw = $urandom_range(1, 4);
      hb = $urandom_range(0, 4);
      vb = $urandom_range(0, 4);
      fn = $urandom_range(1, 3);
      pat = $urandom_range(0, 3);
      cst = $urandom_range(0, (1 << DW) - 1);
      set_p(hw, vw, hb, vb, fn, pat, cst);
      i_en = 1'b1;
      wait_vstr($sformatf("rnd%0d", r));
      for (int unsigned k = 0; k < fn; k++) begin
        if (k > 0) tick();
        run_frame($sformatf("rnd%0d_f%0d", r, k), hw, vw, hb, vb, pat, cst, k == fn - 1, 0);
      end
      check_idle($sformatf("rnd%0d_idle", r), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
